// File: rtl/gfx_mem_arbiter.sv
// Four-port read arbiter in front of a shared fixed-latency memory; port tags ride a shift register
// alongside each mem_rd. Define GFX_MEM_ARB_FIXED_PRIORITY_EN for fixed priority instead of round-robin.
module gfx_mem_arbiter #(
    parameter int unsigned BITS         = 16,
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned MEM_LATENCY  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS-1:0] spcon_memory_address,
    input  logic [ADDRESS_BITS-1:0] bg0_memory_address,
    input  logic [ADDRESS_BITS-1:0] bg1_memory_address,
    input  logic [ADDRESS_BITS-1:0] ov_memory_address,
    input  logic                    spcon_rvalid,
    input  logic                    bg0_rvalid,
    input  logic                    bg1_rvalid,
    input  logic                    ov_rvalid,
    output logic                    spcon_rready,
    output logic                    bg0_rready,
    output logic                    bg1_rready,
    output logic                    ov_rready,
    output logic [BITS-1:0]         spcon_memory_data,
    output logic [BITS-1:0]         bg0_memory_data,
    output logic [BITS-1:0]         bg1_memory_data,
    output logic [BITS-1:0]         ov_memory_data,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic                    mem_rd,
    input  logic                    mem_ready,
    input  logic [BITS-1:0]         mem_rdata
);

    logic [ADDRESS_BITS-1:0] w_addr [4];
    logic [3:0]              w_req;
    logic [3:0]              w_elig;
    logic                    w_gnt_vld;
    logic [1:0]              w_gnt_tag;
    logic [3:0]              w_gnt_oh;
    logic [3:0]              w_rready;

    logic [3:0]              r_busy;
    logic [ADDRESS_BITS-1:0] r_mem_addr;
    logic                    r_mem_rd;
    logic [1:0]              r_mem_tag;
    logic                    r_pipe_vld [MEM_LATENCY];
    logic [1:0]              r_pipe_tag [MEM_LATENCY];
    logic [BITS-1:0]         r_hold     [4];
`ifndef GFX_MEM_ARB_FIXED_PRIORITY_EN
    logic [1:0]              r_ptr;
    logic [1:0]              w_idx;
`endif

    assign w_addr[0] = spcon_memory_address;
    assign w_addr[1] = bg0_memory_address;
    assign w_addr[2] = bg1_memory_address;
    assign w_addr[3] = ov_memory_address;
    assign w_req     = {ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};
    assign w_elig    = w_req & ~r_busy;

    // Loops run high to low so the last hit (lowest search position) wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_tag = 2'd0;
`ifdef GFX_MEM_ARB_FIXED_PRIORITY_EN
        if (mem_ready) begin
            for (int i = 3; i >= 0; i--) begin
                if (w_elig[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_tag = 2'(i);
                end
            end
        end
`else
        w_idx = 2'd0;
        if (mem_ready) begin
            for (int i = 3; i >= 0; i--) begin
                w_idx = r_ptr + 2'(i) + 2'd1;
                if (w_elig[w_idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_tag = w_idx;
                end
            end
        end
`endif
    end

    assign w_gnt_oh = w_gnt_vld ? (4'b0001 << w_gnt_tag) : 4'b0000;
    assign w_rready = r_pipe_vld[MEM_LATENCY-1] ? (4'b0001 << r_pipe_tag[MEM_LATENCY-1]) : 4'b0000;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy     <= 4'b0000;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_tag  <= 2'd0;
`ifndef GFX_MEM_ARB_FIXED_PRIORITY_EN
            r_ptr      <= 2'd3;
`endif
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_tag[i] <= 2'd0;
            end
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_busy    <= (r_busy & ~w_rready) | w_gnt_oh;
            r_mem_rd  <= w_gnt_vld;
            r_mem_tag <= w_gnt_tag;
            if (w_gnt_vld) begin
                r_mem_addr <= w_addr[w_gnt_tag];
`ifndef GFX_MEM_ARB_FIXED_PRIORITY_EN
                r_ptr      <= w_gnt_tag;
`endif
            end
            // Tag enters the pipe the cycle mem_rd is on the bus; it emerges with mem_rdata.
            r_pipe_vld[0] <= r_mem_rd;
            r_pipe_tag[0] <= r_mem_tag;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            for (int i = 0; i < 4; i++) begin
                if (w_rready[i]) begin
                    r_hold[i] <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr          = r_mem_addr;
    assign mem_rd            = r_mem_rd;
    assign spcon_rready      = w_rready[0];
    assign bg0_rready        = w_rready[1];
    assign bg1_rready        = w_rready[2];
    assign ov_rready         = w_rready[3];
    assign spcon_memory_data = w_rready[0] ? mem_rdata : r_hold[0];
    assign bg0_memory_data   = w_rready[1] ? mem_rdata : r_hold[1];
    assign bg1_memory_data   = w_rready[2] ? mem_rdata : r_hold[2];
    assign ov_memory_data    = w_rready[3] ? mem_rdata : r_hold[3];

endmodule
